// File: rtl/rf_write_arbiter_if.sv
// Register-file write-port bundle: three requester handshakes plus the
// registered write port driven into the register file.
interface rf_write_arbiter_if #(
  parameter int W = 8
);
  logic         hold;
  logic         req0_valid;
  logic [2:0]   req0_addr;
  logic [W-1:0] req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [2:0]   req1_addr;
  logic [W-1:0] req1_data;
  logic         req1_ready;
  logic         lr_valid;
  logic [W-1:0] lr_data;
  logic         lr_ready;
  logic         RegWrite;
  logic [2:0]   A3;
  logic [W-1:0] WD3;
  logic [1:0]   grant_id;

  modport master (
    output hold,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output lr_valid, lr_data,
    input  req0_ready, req1_ready, lr_ready,
    input  RegWrite, A3, WD3, grant_id
  );

  modport slave (
    input  hold,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  lr_valid, lr_data,
    output req0_ready, req1_ready, lr_ready,
    output RegWrite, A3, WD3, grant_id
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Single write-port arbiter for the register file: round-robin between ALU and
// load writeback, priority for link-register writes, and a starvation guard.
module rf_write_arbiter #(
  parameter int W        = 8,
  parameter int MAX_WAIT = 3,
  parameter int LR_ADDR  = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  rf_write_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    G_REQ0 = 2'd0,
    G_REQ1 = 2'd1,
    G_LR   = 2'd2,
    G_IDLE = 2'd3
  } grant_t;

  localparam logic [3:0] MAX_WAIT_W = 4'(MAX_WAIT);
  localparam logic [2:0] LR_A       = 3'(LR_ADDR);

  logic         r_rr;
  logic [3:0]   r_wait0;
  logic [3:0]   r_wait1;
  logic         r_reg_write;
  logic [2:0]   r_a3;
  logic [W-1:0] r_wd3;
  grant_t       r_grant_id;

  grant_t       w_grant;
  logic         w_starve0;
  logic         w_starve1;
  logic [2:0]   w_addr;
  logic [W-1:0] w_data;

  assign w_starve0 = bus.req0_valid && (r_wait0 >= MAX_WAIT_W);
  assign w_starve1 = bus.req1_valid && (r_wait1 >= MAX_WAIT_W);

  always_comb begin
    // NOTE: default every output first so no path through the block infers a latch.
    w_grant = G_IDLE;
    if (reset && !bus.hold) begin
      if (w_starve0 && w_starve1)              w_grant = r_rr ? G_REQ1 : G_REQ0;
      else if (w_starve0)                      w_grant = G_REQ0;
      else if (w_starve1)                      w_grant = G_REQ1;
      else if (bus.lr_valid)                   w_grant = G_LR;
      else if (bus.req0_valid && bus.req1_valid) w_grant = r_rr ? G_REQ1 : G_REQ0;
      else if (bus.req0_valid)                 w_grant = G_REQ0;
      else if (bus.req1_valid)                 w_grant = G_REQ1;
    end
  end

  always_comb begin
    w_addr = bus.req0_addr;
    w_data = bus.req0_data;
    case (w_grant)
      G_REQ1: begin
        w_addr = bus.req1_addr;
        w_data = bus.req1_data;
      end
      G_LR: begin
        w_addr = LR_A;
        w_data = bus.lr_data;
      end
      default: ;
    endcase
  end

  assign bus.req0_ready = (w_grant == G_REQ0);
  assign bus.req1_ready = (w_grant == G_REQ1);
  assign bus.lr_ready   = (w_grant == G_LR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rr        <= 1'b0;
      r_wait0     <= 4'd0;
      r_wait1     <= 4'd0;
      r_reg_write <= 1'b0;
      r_a3        <= 3'd0;
      r_wd3       <= '0;
      r_grant_id  <= G_IDLE;
    end else begin
      r_grant_id  <= w_grant;
      r_reg_write <= (w_grant != G_IDLE);
      if (w_grant != G_IDLE) begin
        r_a3  <= w_addr;
        r_wd3 <= w_data;
      end

      if (w_grant == G_REQ0)      r_rr <= 1'b1;
      else if (w_grant == G_REQ1) r_rr <= 1'b0;

      // Blocked cycles include hold cycles, so a long hold leaves both starving.
      if (!bus.req0_valid || w_grant == G_REQ0) r_wait0 <= 4'd0;
      else if (r_wait0 != 4'hF)                 r_wait0 <= r_wait0 + 4'd1;

      if (!bus.req1_valid || w_grant == G_REQ1) r_wait1 <= 4'd0;
      else if (r_wait1 != 4'hF)                 r_wait1 <= r_wait1 + 4'd1;
    end
  end

  assign bus.RegWrite = r_reg_write;
  assign bus.A3       = r_a3;
  assign bus.WD3      = r_wd3;
  assign bus.grant_id = r_grant_id;

endmodule
